cic_comb: RTL and testbench

//  Comb section of the Hogenauer CIC decimator, clocked in the clk_div (decimated) domain.

---
 rtl/cic_pkg.sv | 49 ++++
 rtl/cic_comb_stage.sv | 29 ++
 rtl/cic_comb.sv | 169 ++++++++++++++++
 tb/tb_cic_comb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC comb section.
package cic_pkg;

  localparam int unsigned OS_W   = 3;
  localparam int unsigned FLAG_W = 2;
  localparam int unsigned SAT_W  = 64;

  typedef enum logic [OS_W-1:0] {
    OS_NONE = 3'd0,
    OS2     = 3'd1,
    OS4     = 3'd2,
    OS8     = 3'd3,
    OS16    = 3'd4,
    OS32    = 3'd5,
    OS64    = 3'd6,
    OS_INV  = 3'd7
  } os_sel_e;

  // Integrator flag pair: sign of the overflow and a toggle per truncation event.
  typedef struct packed {
    logic sign;
    logic tog;
  } flag_t;

  // Codes 0 and 7 carry no decimation, so the comb passes samples through.
  function automatic logic is_bypass(input logic [OS_W-1:0] os_sel);
    return (os_sel == OS_NONE) || (os_sel == OS_INV);
  endfunction

  // CIC gain is 2^(log2(R)*NSTAGE); the shift removes it.
  function automatic int unsigned gain_shift(input logic [OS_W-1:0] os_sel,
                                             input int unsigned     nstage);
    if (is_bypass(os_sel)) return 0;
    return 32'(os_sel) * nstage;
  endfunction

  // Clamp a signed value to the range of an odw-bit two's complement word.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] val,
                                                  input int unsigned             odw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (odw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One pipelined comb difference stage (M=1) with bypass and history flush.
module cic_comb_stage #(
  parameter int unsigned W = 23
) (
  input  logic         clk_div,
  input  logic         reset_n,
  input  logic         i_bypass,
  input  logic         i_flush,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  logic [W-1:0] r_hist;
  logic [W-1:0] r_y;

  // Difference against the previous sample; modulo 2^W wrap is what the CIC relies on.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
      r_y    <= '0;
    end else begin
      r_hist <= i_flush ? '0 : i_x;
      r_y    <= i_bypass ? i_x : (i_x - r_hist);
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/cic_comb.sv
// CIC decimator comb section: NSTAGE differences, gain removal, rounding,
// saturation, forced overflow on integrator flag events and overflow status.
module cic_comb
  import cic_pkg::*;
#(
  parameter int unsigned IDW    = 23,
  parameter int unsigned ODW    = 16,
  parameter int unsigned NSTAGE = 1,
  parameter int unsigned CNTW   = 8
) (
  input  logic            clk_div,
  input  logic            reset_n,
  input  logic [2:0]      os_sel,
  input  logic [IDW-1:0]  data_in,
  input  logic [1:0]      flag_in,
  input  logic            ovf_clr,
  output logic [ODW-1:0]  data_out,
  output logic            data_valid,
  output logic            ovf,
  output logic            ovf_sticky,
  output logic [CNTW-1:0] ovf_cnt
);

  localparam int unsigned WARM = 2 * NSTAGE + 1;
  localparam int unsigned WW   = $clog2(WARM + 1);
  localparam int unsigned RW   = IDW + 1;

  logic [2:0]              r_os_d;
  logic                    r_flag_prev;
  logic [WW-1:0]           r_warm;
  logic [ODW-1:0]          r_data_out;
  logic                    r_valid;
  logic                    r_ovf;
  logic                    r_sticky;
  logic [CNTW-1:0]         r_cnt;
  logic                    r_evt_dly [NSTAGE];
  logic                    r_sgn_dly [NSTAGE];

  flag_t                   w_flag;
  logic                    w_evt;
  logic                    w_change;
  logic                    w_bypass;
  logic [IDW-1:0]          w_stage [NSTAGE+1];
  int unsigned             w_shift;
  logic signed [RW-1:0]    w_ext;
  logic signed [RW-1:0]    w_rnd;
  logic signed [RW-1:0]    w_scaled;
  logic signed [SAT_W-1:0] w_wide;
  logic signed [SAT_W-1:0] w_sat;
  logic [ODW-1:0]          w_data_nxt;
  logic                    w_ovf_nxt;
  logic [WW-1:0]           w_warm_nxt;
  logic                    w_valid_nxt;
  logic                    w_count;

  assign w_flag   = flag_t'(flag_in);
  assign w_evt    = w_flag.tog != r_flag_prev;
  assign w_change = os_sel != r_os_d;
  assign w_bypass = is_bypass(r_os_d);

  assign w_stage[0] = data_in;

  // Comb chain; a mode change zeroes every stage history on the same edge.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    cic_comb_stage #(.W(IDW)) u_stage (
      .clk_div  (clk_div),
      .reset_n  (reset_n),
      .i_bypass (w_bypass),
      .i_flush  (w_change),
      .i_x      (w_stage[k]),
      .o_y      (w_stage[k+1])
    );
  end

  // Flag event delay line, one tap per comb stage so it meets its sample at the output.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_flag_dly
    if (k == 0) begin : g_head
      always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
          r_evt_dly[k] <= 1'b0;
          r_sgn_dly[k] <= 1'b0;
        end else begin
          r_evt_dly[k] <= w_evt;
          r_sgn_dly[k] <= w_flag.sign;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
          r_evt_dly[k] <= 1'b0;
          r_sgn_dly[k] <= 1'b0;
        end else begin
          r_evt_dly[k] <= r_evt_dly[k-1];
          r_sgn_dly[k] <= r_sgn_dly[k-1];
        end
      end
    end
  end

  // Gain removal with round-half-up, saturation and flag forcing.
  always_comb begin
    w_shift    = gain_shift(r_os_d, NSTAGE);
    w_ext      = {w_stage[NSTAGE][IDW-1], w_stage[NSTAGE]};
    w_rnd      = w_ext;
    if (w_shift != 0) begin
      w_rnd = w_ext + (RW'(1) << (w_shift - 1));
    end
    w_scaled   = w_rnd >>> w_shift;
    w_wide     = SAT_W'(w_scaled);
    w_sat      = sat(w_wide, ODW);
    w_data_nxt = w_sat[ODW-1:0];
    w_ovf_nxt  = w_sat != w_wide;
    if (r_evt_dly[NSTAGE-1]) begin
      w_data_nxt = r_sgn_dly[NSTAGE-1] ? {1'b1, {(ODW-1){1'b0}}} : {1'b0, {(ODW-1){1'b1}}};
      w_ovf_nxt  = 1'b1;
    end
  end

  // Warm-up countdown restarts on any oversampling change.
  always_comb begin
    w_warm_nxt = r_warm;
    if (w_change) begin
      w_warm_nxt = WW'(WARM);
    end else if (r_warm != '0) begin
      w_warm_nxt = r_warm - WW'(1);
    end
    w_valid_nxt = w_warm_nxt == '0;
    w_count     = w_ovf_nxt && w_valid_nxt;
  end

  // Output, warm-up and overflow status registers.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      r_os_d      <= '0;
      r_flag_prev <= 1'b0;
      r_warm      <= WW'(WARM);
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_os_d      <= os_sel;
      r_flag_prev <= w_flag.tog;
      r_warm      <= w_warm_nxt;
      r_data_out  <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_ovf       <= w_ovf_nxt;
      if (w_count) begin
        r_sticky <= 1'b1;
        if (ovf_clr) begin
          r_cnt <= CNTW'(1);
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end else if (ovf_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign ovf_cnt    = r_cnt;

endmodule

// File: tb/tb_cic_comb.sv
// Directed bench for cic_comb (NSTAGE=1): vector table plus corner sequences.
module tb_cic_comb;

  localparam int unsigned IDW    = 23;
  localparam int unsigned ODW    = 16;
  localparam int unsigned NSTAGE = 1;
  localparam int unsigned CNTW   = 8;
  localparam int unsigned WARM   = 2 * NSTAGE + 1;
  localparam int          NV     = 16;

  logic            clk_div = 1'b0;
  logic            reset_n;
  logic [2:0]      os_sel;
  logic [IDW-1:0]  data_in;
  logic [1:0]      flag_in;
  logic            ovf_clr;
  logic [ODW-1:0]  data_out;
  logic            data_valid;
  logic            ovf;
  logic            ovf_sticky;
  logic [CNTW-1:0] ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [IDW-1:0] acc;

  typedef struct {
    logic [2:0]     os;
    logic [IDW-1:0] base;
    int             stp;
    logic [ODW-1:0] exp_out;
    logic           exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  cic_comb #(.IDW(IDW), .ODW(ODW), .NSTAGE(NSTAGE), .CNTW(CNTW)) dut (
    .clk_div    (clk_div),
    .reset_n    (reset_n),
    .os_sel     (os_sel),
    .data_in    (data_in),
    .flag_in    (flag_in),
    .ovf_clr    (ovf_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk_div = ~clk_div;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_div);
      #1;
    end
  endtask

  task automatic ramp(input int n, input int stp);
    repeat (n) begin
      data_in = acc;
      step(1);
      acc = acc + IDW'(stp);
    end
  endtask

  initial begin
    //            os    base        step     out        ovf
    vecs[0]  = '{3'd3, 23'h0,      8000,    16'd1000,  1'b0};
    vecs[1]  = '{3'd3, 23'h0,      262139,  16'h7FFF,  1'b0};
    vecs[2]  = '{3'd3, 23'h0,      262140,  16'h7FFF,  1'b1};
    vecs[3]  = '{3'd3, 23'h0,      -262148, 16'h8000,  1'b0};
    vecs[4]  = '{3'd3, 23'h0,      -262149, 16'h8000,  1'b1};
    vecs[5]  = '{3'd0, 23'h000123, 0,       16'h0123,  1'b0};
    vecs[6]  = '{3'd0, 23'h010000, 0,       16'h7FFF,  1'b1};
    vecs[7]  = '{3'd0, 23'h007FFF, 0,       16'h7FFF,  1'b0};
    vecs[8]  = '{3'd7, 23'h7F0000, 0,       16'h8000,  1'b1};
    vecs[9]  = '{3'd1, 23'h0,      3,       16'd2,     1'b0};
    vecs[10] = '{3'd1, 23'h0,      -3,      16'hFFFF,  1'b0};
    vecs[11] = '{3'd1, 23'h0,      23'h400000, 16'h8000, 1'b1};
    vecs[12] = '{3'd2, 23'h0,      2,       16'd1,     1'b0};
    vecs[13] = '{3'd2, 23'h0,      -6,      16'hFFFF,  1'b0};
    vecs[14] = '{3'd6, 23'h0,      -100,    16'hFFFE,  1'b0};
    vecs[15] = '{3'd5, 23'h0,      8000,    16'd250,   1'b0};

    reset_n = 1'b0;
    os_sel  = 3'd0;
    data_in = '0;
    flag_in = 2'b00;
    ovf_clr = 1'b0;
    acc     = '0;

    // Reset state
    #12;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_sticky", 32'(ovf_sticky), 32'h0);
    chk("rst_cnt", 32'(ovf_cnt), 32'h0);

    // Warm-up after release: valid rises exactly WARM edges later
    reset_n = 1'b1;
    data_in = 23'h55;
    for (int i = 1; i < int'(WARM); i++) begin
      step(1);
      chk("warm_valid_low", 32'(data_valid), 32'h0);
    end
    step(1);
    chk("warm_valid_high", 32'(data_valid), 32'h1);

    // Bypass latency of two clk_div cycles
    step(3);
    data_in = 23'h000123;
    step(1);
    chk("lat_1cyc", 32'(data_out), 32'h55);
    step(1);
    chk("lat_2cyc", 32'(data_out), 32'h123);

    // Vector table: settle each mode/stimulus then compare
    for (int v = 0; v < NV; v++) begin
      os_sel = vecs[v].os;
      acc    = vecs[v].base;
      ramp(10, vecs[v].stp);
      chk($sformatf("vec%0d_valid", v), 32'(data_valid), 32'h1);
      chk($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].exp_out));
      chk($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
    end

    // Flag events in bypass
    os_sel  = 3'd0;
    data_in = 23'h55;
    step(6);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("clr_sticky", 32'(ovf_sticky), 32'h0);
    chk("clr_cnt", 32'(ovf_cnt), 32'h0);
    flag_in = 2'b11;
    step(1);
    chk("flag_neg_early", 32'(data_out), 32'h55);
    step(1);
    chk("flag_neg_data", 32'(data_out), 32'h8000);
    chk("flag_neg_ovf", 32'(ovf), 32'h1);
    chk("flag_neg_sticky", 32'(ovf_sticky), 32'h1);
    chk("flag_neg_cnt", 32'(ovf_cnt), 32'h1);
    step(1);
    chk("flag_after_data", 32'(data_out), 32'h55);
    chk("flag_after_ovf", 32'(ovf), 32'h0);
    flag_in = 2'b00;
    step(2);
    chk("flag_pos_data", 32'(data_out), 32'h7FFF);
    chk("flag_pos_cnt", 32'(ovf_cnt), 32'h2);

    // Clear coinciding with a counted event, then counter saturation
    data_in = 23'h010000;
    step(4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("clr_evt_sticky", 32'(ovf_sticky), 32'h1);
    chk("clr_evt_cnt", 32'(ovf_cnt), 32'h1);
    step(300);
    chk("cnt_sat", 32'(ovf_cnt), 32'hFF);
    chk("cnt_sat_sticky", 32'(ovf_sticky), 32'h1);

    // Mode change 3 -> 5 mid-ramp
    os_sel = 3'd3;
    acc    = '0;
    ramp(10, 8000);
    chk("mode3_data", 32'(data_out), 32'd1000);
    os_sel = 3'd5;
    for (int i = 0; i < int'(WARM); i++) begin
      ramp(1, 8000);
      chk("mode_chg_valid_low", 32'(data_valid), 32'h0);
    end
    ramp(1, 8000);
    chk("mode5_valid", 32'(data_valid), 32'h1);
    chk("mode5_data", 32'(data_out), 32'd250);
    chk("mode5_cnt_held", 32'(ovf_cnt), 32'hFF);

    // Asynchronous reset mid-ramp
    ramp(2, 8000);
    reset_n = 1'b0;
    #2;
    chk("arst_data_out", 32'(data_out), 32'h0);
    chk("arst_valid", 32'(data_valid), 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    chk("arst_sticky", 32'(ovf_sticky), 32'h0);
    chk("arst_cnt", 32'(ovf_cnt), 32'h0);
    step(2);
    chk("arst_held_valid", 32'(data_valid), 32'h0);
    reset_n = 1'b1;
    step(1);
    chk("arst_release_valid", 32'(data_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
